// File: rtl/square_accum.sv
// Block accumulator: sums NSAMP upstream squares and holds the result until consumed.
// Build option: define SQUARE_ACCUM_SAT_EN to saturate acc on overflow instead of wrapping.
module square_accum #(
  parameter int unsigned NSAMP = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       square,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(NSAMP) + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oflag_q, oflag_d;
  logic             ovf_q, ovf_d;
  logic             live_q;
  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] acc_next;
  logic             carry;
  logic             accept;

  always_comb begin
    add_full = {1'b0, acc_q} + (ACC_W+1)'(square);
    carry    = add_full[ACC_W];
`ifdef SQUARE_ACCUM_SAT_EN
    // Once saturated, the sticky flag pins acc at full scale for the rest of the block.
    acc_next = (oflag_q || carry) ? '1 : add_full[ACC_W-1:0];
`else
    acc_next = add_full[ACC_W-1:0];
`endif
  end

  always_comb begin
    in_ready  = live_q && (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    oflag_d = oflag_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      oflag_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d   = acc_next;
            cnt_d   = cnt_q + 1'b1;
            oflag_d = oflag_q | carry;
            if (cnt_q == CNT_W'(NSAMP - 1)) begin
              sum_d   = acc_next;
              ovf_d   = oflag_q | carry;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            oflag_d = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      oflag_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      oflag_q <= oflag_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_square_accum.sv
// Directed bench for square_accum: a 4x12 instance with a scoreboard and an 8-bit 2-sample instance.
module tb_square_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sq0, sq1;
  logic       iv0, iv1, clr0, clr1, ordy0, ordy1;
  logic       ir0, ir1, ov0, vld1, ovf0, ovf1;
  logic [11:0] sum0;
  logic [7:0]  sum1;

  int total = 0;
  int bad   = 0;
  int m_sum = 0;
  int m_cnt = 0;

  typedef struct { int s; int o; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  square_accum #(.NSAMP(4), .ACC_W(12)) u0 (
    .clk(clk), .rst_n(rst_n), .square(sq0), .in_valid(iv0), .in_ready(ir0),
    .clear(clr0), .sum(sum0), .ovf(ovf0), .out_valid(ov0), .out_ready(ordy0)
  );

  square_accum #(.NSAMP(2), .ACC_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .square(sq1), .in_valid(iv1), .in_ready(ir1),
    .clear(clr1), .sum(sum1), .ovf(ovf1), .out_valid(vld1), .out_ready(ordy1)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_accept(input int s);
    exp_t e;
    m_sum += s;
    m_cnt++;
    if (m_cnt == 4) begin
`ifdef SQUARE_ACCUM_SAT_EN
      e.s = (m_sum > 4095) ? 4095 : m_sum;
`else
      e.s = m_sum % 4096;
`endif
      e.o = (m_sum > 4095) ? 1 : 0;
      sb.push_back(e);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic send0(input int s);
    bit acc;
    sq0 = 8'(s);
    iv0 = 1'b1;
    for (int i = 0; i < 20 && !ir0; i++) begin
      @(posedge clk); #1;
    end
    chk("u0_ready_wait", int'(ir0), 1);
    acc = ir0;
    @(posedge clk); #1;
    iv0 = 1'b0;
    if (acc) model_accept(s);
  endtask

  task automatic check_out0(input string tag);
    exp_t e;
    chk({tag, "_valid"}, int'(ov0), 1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, sb.size(), 1);
    else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, int'(sum0), e.s);
      chk({tag, "_ovf"}, int'(ovf0), e.o);
    end
  endtask

  task automatic send1(input int s);
    sq1 = 8'(s);
    iv1 = 1'b1;
    for (int i = 0; i < 20 && !ir1; i++) begin
      @(posedge clk); #1;
    end
    chk("u1_ready_wait", int'(ir1), 1);
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  task automatic pair1(input string tag, input int a, input int b, input int es, input int eo);
    send1(a);
    send1(b);
    chk({tag, "_valid"}, int'(vld1), 1);
    chk({tag, "_sum"}, int'(sum1), es);
    chk({tag, "_ovf"}, int'(ovf1), eo);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sq0 = '0; iv0 = 1'b0; clr0 = 1'b0; ordy0 = 1'b1;
    sq1 = '0; iv1 = 1'b0; clr1 = 1'b0; ordy1 = 1'b1;
    #3;
    chk("rst_in_ready", int'(ir0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_sum", int'(sum0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    #5 rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", int'(ir0), 0);
    @(posedge clk); #1;
    chk("rel_in_ready_post_edge", int'(ir0), 1);

    // Test 1: back-to-back block, result one cycle after last accept
    send0(225); send0(25); send0(81); send0(1);
    check_out0("t1");
    chk("t1_in_ready_hold", int'(ir0), 0);
    @(posedge clk); #1;
    chk("t1_after_hs_valid", int'(ov0), 0);
    chk("t1_after_hs_ready", int'(ir0), 1);
    chk("t1_sum_kept", int'(sum0), 332);

    // Test 2: narrow accumulator overflow and boundary
`ifdef SQUARE_ACCUM_SAT_EN
    pair1("t2_ovf", 225, 225, 255, 1);
    pair1("t2_edge_max", 225, 30, 255, 0);
    pair1("t2_edge_over", 225, 31, 255, 1);
`else
    pair1("t2_ovf", 225, 225, 194, 1);
    pair1("t2_edge_max", 225, 30, 255, 0);
    pair1("t2_edge_over", 225, 31, 0, 1);
`endif

    // Test 3: backpressure in HOLD with upstream offering data
    ordy0 = 1'b0;
    send0(100); send0(49); send0(36); send0(4);
    check_out0("t3");
    sq0 = 8'd9;
    iv0 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_hold_ready", int'(ir0), 0);
      chk("t3_hold_valid", int'(ov0), 1);
      chk("t3_hold_sum", int'(sum0), 189);
    end
    ordy0 = 1'b1;
    @(posedge clk); #1;
    chk("t3_hs_valid", int'(ov0), 0);
    chk("t3_hs_ready", int'(ir0), 1);
    send0(9); send0(1); send0(1); send0(1);
    check_out0("t3b");
    @(posedge clk); #1;

    // Test 4: reset mid-block
    send0(9); send0(16);
    rst_n = 1'b0;
    #2;
    chk("t4_rst_ready", int'(ir0), 0);
    chk("t4_rst_valid", int'(ov0), 0);
    chk("t4_rst_sum", int'(sum0), 0);
    chk("t4_rst_ovf", int'(ovf0), 0);
    m_sum = 0;
    m_cnt = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t4_rel_ready", int'(ir0), 1);
    send0(1); send0(4); send0(9); send0(16);
    check_out0("t4");
    @(posedge clk); #1;

    // Test 5: clear drops the concurrent sample and the partial block
    send0(1); send0(1); send0(1);
    clr0 = 1'b1; sq0 = 8'd200; iv0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0; iv0 = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    chk("t5_clr_ready", int'(ir0), 1);
    chk("t5_clr_valid", int'(ov0), 0);
    send0(64); send0(64); send0(64); send0(64);
    check_out0("t5");
    @(posedge clk); #1;

    // Test 5b: clear discards a pending HOLD result
    ordy0 = 1'b0;
    send0(2); send0(2); send0(2); send0(2);
    chk("t5b_hold_valid", int'(ov0), 1);
    if (sb.size() > 0) void'(sb.pop_back());
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("t5b_clr_valid", int'(ov0), 0);
    chk("t5b_clr_ready", int'(ir0), 1);
    ordy0 = 1'b1;
    send0(3); send0(3); send0(3); send0(3);
    check_out0("t5b");
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
